// File: rtl/sap_ctrl_seq.sv
// ---------------------------------------------------------------------------
// sap_ctrl_seq
// Controller-sequencer for the 8-bit SAP datapath. A six-state one-hot ring
// counter (T1..T6) steps each instruction through fetch and execute. The IR
// opcode is decoded into the load/enable/count strobes for the PC, MAR, RAM,
// IR, accumulator, register B, ALU and output register.
//
// Ports
//   CLK     in   system clock, all state changes on the rising edge
//   nCLR    in   synchronous active-low clear
//   opcode  in   [3:0] IR upper nibble, only looked at in T4..T6
//   Cp      out  PC increment
//   Ep      out  PC drives DBUS
//   Lm      out  MAR loads from DBUS
//   CE      out  RAM drives DBUS
//   Li      out  IR loads from DBUS
//   Ei      out  IR operand nibble drives DBUS
//   La      out  accumulator loads from DBUS
//   Ea      out  accumulator drives DBUS
//   Su      out  ALU op select (0 add, 1 subtract)
//   Eu      out  ALU drives DBUS
//   Lb      out  register B loads from DBUS
//   Lo      out  output register loads from DBUS
//   HLT     out  halted flag (also gates the system clock)
//   T       out  [5:0] one-hot ring state, bit0 = T1 .. bit5 = T6
// ---------------------------------------------------------------------------
module sap_ctrl_seq #(
    parameter bit SHORT_CYCLE = 1'b0
) (
    input  logic       CLK,
    input  logic       nCLR,
    input  logic [3:0] opcode,
    output logic       Cp,
    output logic       Ep,
    output logic       Lm,
    output logic       CE,
    output logic       Li,
    output logic       Ei,
    output logic       La,
    output logic       Ea,
    output logic       Su,
    output logic       Eu,
    output logic       Lb,
    output logic       Lo,
    output logic       HLT,
    output logic [5:0] T
);

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    logic [5:0] t_q;
    logic [5:0] t_d;
    logic       halt_q;
    logic       halt_d;
    logic [5:0] t_rot_s;

    // True when exactly one bit of the ring is set.
    function automatic logic is_onehot6(input logic [5:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 6; i++) begin
            n = n + {2'b00, v[i]};
        end
        return (n == 3'd1);
    endfunction

    assign t_rot_s = {t_q[4:0], t_q[5]};
    assign T       = t_q;

    // State register: ring counter and halt latch, synchronous clear.
    always_ff @(posedge CLK) begin
        if (!nCLR) begin
            t_q    <= T1;
            halt_q <= 1'b0;
        end else begin
            t_q    <= t_d;
            halt_q <= halt_d;
        end
    end

    // Next-state logic: ring advance, halt freeze and optional early return to T1.
    always_comb begin
        t_d    = t_rot_s;
        halt_d = halt_q;
        if (!is_onehot6(t_q)) begin
            // A corrupted ring restarts the instruction rather than wandering.
            t_d = T1;
        end else if (halt_q) begin
            t_d = t_q;
        end else begin
            case (t_q)
                T4: begin
                    case (opcode)
                        OP_HLT: begin
                            halt_d = 1'b1;
                            t_d    = t_q;
                        end
                        OP_LDA, OP_ADD, OP_SUB: t_d = t_rot_s;
                        // OUT and undefined opcodes have nothing left after T4.
                        default: t_d = SHORT_CYCLE ? T1 : t_rot_s;
                    endcase
                end
                T5: begin
                    if (SHORT_CYCLE && (opcode == OP_LDA)) begin
                        t_d = T1;
                    end else begin
                        t_d = t_rot_s;
                    end
                end
                default: t_d = t_rot_s;
            endcase
        end
    end

    // Output decode: control word from ring state, halt latch and opcode.
    always_comb begin
        Cp  = 1'b0;
        Ep  = 1'b0;
        Lm  = 1'b0;
        CE  = 1'b0;
        Li  = 1'b0;
        Ei  = 1'b0;
        La  = 1'b0;
        Ea  = 1'b0;
        Su  = 1'b0;
        Eu  = 1'b0;
        Lb  = 1'b0;
        Lo  = 1'b0;
        HLT = 1'b0;
        if (!nCLR) begin
            HLT = 1'b0;
        end else if (halt_q) begin
            HLT = 1'b1;
        end else begin
            case (t_q)
                T1: begin
                    Ep = 1'b1;
                    Lm = 1'b1;
                end
                T2: Cp = 1'b1;
                T3: begin
                    CE = 1'b1;
                    Li = 1'b1;
                end
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            Ei = 1'b1;
                            Lm = 1'b1;
                        end
                        OP_OUT: begin
                            Ea = 1'b1;
                            Lo = 1'b1;
                        end
                        // HLT shows up in T4 before the latch sets on the edge.
                        OP_HLT:  HLT = 1'b1;
                        default: HLT = 1'b0;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDA: begin
                            CE = 1'b1;
                            La = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            CE = 1'b1;
                            Lb = 1'b1;
                        end
                        default: HLT = 1'b0;
                    endcase
                end
                T6: begin
                    case (opcode)
                        OP_ADD: begin
                            Eu = 1'b1;
                            La = 1'b1;
                        end
                        OP_SUB: begin
                            Eu = 1'b1;
                            La = 1'b1;
                            Su = 1'b1;
                        end
                        default: HLT = 1'b0;
                    endcase
                end
                default: HLT = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_sap_ctrl_seq.sv
// Bench for sap_ctrl_seq: directed instruction sequences on a full-length
// instance and a short-cycle instance; expected {T, control word} pushed per
// cycle, popped and compared by a negedge monitor. A small SAP datapath model
// driven by the full-length instance runs a short program.
module tb_sap_ctrl_seq;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Control word bit order: Cp Ep Lm CE Li Ei La Ea Su Eu Lb Lo HLT
    localparam logic [12:0] W_NONE   = 13'h0000;
    localparam logic [12:0] W_EPLM   = 13'h0C00;
    localparam logic [12:0] W_CP     = 13'h1000;
    localparam logic [12:0] W_CELI   = 13'h0300;
    localparam logic [12:0] W_EILM   = 13'h0480;
    localparam logic [12:0] W_CELA   = 13'h0240;
    localparam logic [12:0] W_CELB   = 13'h0204;
    localparam logic [12:0] W_EULA   = 13'h0048;
    localparam logic [12:0] W_EULASU = 13'h0058;
    localparam logic [12:0] W_EALO   = 13'h0022;
    localparam logic [12:0] W_HLT    = 13'h0001;

    logic       nclr0, nclr1;
    logic [3:0] op0_drv, op1, opcode0;
    logic       prog_mode;
    wire  [12:0] ctl0, ctl1;
    wire  [5:0]  t0, t1;

    logic [18:0] q0[$];
    logic [18:0] q1[$];
    logic [7:0]  out_q[$];
    int tests = 0;
    int fails = 0;
    logic started = 1'b0;
    logic done = 1'b0;
    logic pend_out = 1'b0;

    // Datapath model
    logic [7:0] ram [16];
    logic [3:0] pc, mar;
    logic [7:0] ir, a, b, outr, bus;

    assign opcode0 = prog_mode ? ir[7:4] : op0_drv;

    sap_ctrl_seq #(.SHORT_CYCLE(1'b0)) dut0 (
        .CLK(CLK), .nCLR(nclr0), .opcode(opcode0),
        .Cp(ctl0[12]), .Ep(ctl0[11]), .Lm(ctl0[10]), .CE(ctl0[9]), .Li(ctl0[8]),
        .Ei(ctl0[7]), .La(ctl0[6]), .Ea(ctl0[5]), .Su(ctl0[4]), .Eu(ctl0[3]),
        .Lb(ctl0[2]), .Lo(ctl0[1]), .HLT(ctl0[0]), .T(t0)
    );

    sap_ctrl_seq #(.SHORT_CYCLE(1'b1)) dut1 (
        .CLK(CLK), .nCLR(nclr1), .opcode(op1),
        .Cp(ctl1[12]), .Ep(ctl1[11]), .Lm(ctl1[10]), .CE(ctl1[9]), .Li(ctl1[8]),
        .Ei(ctl1[7]), .La(ctl1[6]), .Ea(ctl1[5]), .Su(ctl1[4]), .Eu(ctl1[3]),
        .Lb(ctl1[2]), .Lo(ctl1[1]), .HLT(ctl1[0]), .T(t1)
    );

    // Datapath bus: whichever block dut0 enables.
    always_comb begin
        bus = 8'h00;
        if (ctl0[11])     bus = {4'h0, pc};
        else if (ctl0[9]) bus = ram[mar];
        else if (ctl0[7]) bus = {4'h0, ir[3:0]};
        else if (ctl0[5]) bus = a;
        else if (ctl0[3]) bus = ctl0[4] ? (a - b) : (a + b);
        else              bus = 8'h00;
    end

    // Datapath registers follow dut0's strobes.
    always @(posedge CLK) begin
        if (!nclr0) begin
            pc <= 4'h0; mar <= 4'h0; ir <= 8'h00; a <= 8'h00; b <= 8'h00; outr <= 8'h00;
        end else begin
            if (ctl0[12]) pc <= pc + 4'h1;
            if (ctl0[10]) mar <= bus[3:0];
            if (ctl0[8])  ir <= bus;
            if (ctl0[6])  a <= bus;
            if (ctl0[2])  b <= bus;
            if (ctl0[1])  outr <= bus;
        end
    end

    // Hand table of the control word for ring step k (1..6) of opcode op.
    function automatic logic [12:0] exp_ctrl(input int k, input logic [3:0] op);
        logic [12:0] w;
        w = W_NONE;
        case (k)
            1: w = W_EPLM;
            2: w = W_CP;
            3: w = W_CELI;
            4: begin
                if (op == 4'h0 || op == 4'h1 || op == 4'h2) w = W_EILM;
                else if (op == 4'hE) w = W_EALO;
                else if (op == 4'hF) w = W_HLT;
                else w = W_NONE;
            end
            5: begin
                if (op == 4'h0) w = W_CELA;
                else if (op == 4'h1 || op == 4'h2) w = W_CELB;
                else w = W_NONE;
            end
            6: begin
                if (op == 4'h1) w = W_EULA;
                else if (op == 4'h2) w = W_EULASU;
                else w = W_NONE;
            end
            default: w = W_NONE;
        endcase
        return w;
    endfunction

    function automatic logic inv_ok(input logic [12:0] c, input logic [5:0] t);
        logic [4:0] drv;
        drv = {c[11], c[9], c[7], c[5], c[3]};
        if ((^{c, t}) === 1'bx) return 1'b0;
        return ($countones(drv) <= 1) && !(c[12] && (|drv)) && ($countones(t) == 1);
    endfunction

    // One cycle: drive inputs after the edge and queue the expected response.
    task automatic cyc(input int sel, input logic nclr, input logic [3:0] op,
                       input logic [5:0] t, input logic [12:0] ctl);
        @(posedge CLK);
        #2;
        if (sel == 0) begin
            nclr0 = nclr; op0_drv = op; q0.push_back({t, ctl});
        end else begin
            nclr1 = nclr; op1 = op; q1.push_back({t, ctl});
        end
    endtask

    // One instruction of len cycles; abort_at > 0 pulls nCLR low in that step.
    task automatic instr(input int sel, input logic [3:0] op, input int len, input int abort_at);
        logic [5:0] tv;
        for (int k = 1; k <= len; k++) begin
            tv = 6'(1 << (k - 1));
            if (abort_at != 0 && k == abort_at) begin
                cyc(sel, 1'b0, op, tv, W_NONE);
                return;
            end else begin
                cyc(sel, 1'b1, op, tv, exp_ctrl(k, op));
            end
        end
    endtask

    // Monitor: invariants every cycle, scoreboard pops, program output check.
    always @(negedge CLK) begin
        logic [18:0] e;
        logic [7:0]  eo;
        if (started) begin
            tests++;
            if (!inv_ok(ctl0, t0)) begin
                fails++;
                $display("FAIL inv0 at %0t: ctl=%b T=%b breaks bus/Cp/one-hot rule", $time, ctl0, t0);
            end
            tests++;
            if (!inv_ok(ctl1, t1)) begin
                fails++;
                $display("FAIL inv1 at %0t: ctl=%b T=%b breaks bus/Cp/one-hot rule", $time, ctl1, t1);
            end
        end
        if (q0.size() > 0) begin
            e = q0.pop_front();
            tests++;
            if ({t0, ctl0} !== e) begin
                fails++;
                $display("FAIL seq0 at %0t: got T=%b ctl=%b, expected T=%b ctl=%b",
                         $time, t0, ctl0, e[18:13], e[12:0]);
            end
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            tests++;
            if ({t1, ctl1} !== e) begin
                fails++;
                $display("FAIL seq1 at %0t: got T=%b ctl=%b, expected T=%b ctl=%b",
                         $time, t1, ctl1, e[18:13], e[12:0]);
            end
        end
        if (pend_out) begin
            tests++;
            if (out_q.size() == 0) begin
                fails++;
                $display("FAIL out_reg at %0t: unexpected load, got %h", $time, outr);
            end else begin
                eo = out_q.pop_front();
                if (outr !== eo) begin
                    fails++;
                    $display("FAIL out_reg at %0t: got %h, expected %h", $time, outr, eo);
                end
            end
        end
        pend_out = prog_mode && nclr0 && ctl0[1];
        if (done) begin
            tests++;
            if (q0.size() != 0 || q1.size() != 0 || out_q.size() != 0) begin
                fails++;
                $display("FAIL drain: q0=%0d q1=%0d out=%0d entries left", q0.size(), q1.size(), out_q.size());
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;
        ram[0] = 8'h0A; ram[1] = 8'h1B; ram[2] = 8'hE0; ram[3] = 8'h0C;
        ram[4] = 8'h2A; ram[5] = 8'hE0; ram[6] = 8'hF0;
        ram[10] = 8'h05; ram[11] = 8'h03; ram[12] = 8'h03;
        prog_mode = 1'b0;
        nclr0 = 1'b0; nclr1 = 1'b0; op0_drv = 4'h0; op1 = 4'h0;

        // Reset held for two cycles on both instances.
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK);
            #2;
            started = 1'b1;
            q0.push_back({6'b000001, W_NONE});
            q1.push_back({6'b000001, W_NONE});
        end

        // Full-length instance: every defined and undefined opcode.
        instr(0, 4'h1, 6, 0);
        instr(0, 4'h2, 6, 0);
        instr(0, 4'h0, 6, 0);
        instr(0, 4'hE, 6, 0);
        for (int o = 3; o <= 13; o++) instr(0, 4'(o), 6, 0);
        // ADD cleared during T5: no Lb, restart at T1.
        instr(0, 4'h1, 6, 5);
        instr(0, 4'h0, 6, 0);
        instr(0, 4'hE, 6, 0);
        instr(0, 4'h7, 6, 0);
        // HLT: freeze at T4 for ten cycles whatever the opcode, then clear.
        instr(0, 4'hF, 4, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1'b1, 4'(i + 1), 6'b001000, W_HLT);
        cyc(0, 1'b0, 4'h0, 6'b001000, W_NONE);

        // Program through the datapath model: A=5+3 -> OUT 08, A=3-5 -> OUT FE.
        prog_mode = 1'b1;
        out_q.push_back(8'h08);
        out_q.push_back(8'hFE);
        instr(0, 4'h0, 6, 0);
        instr(0, 4'h1, 6, 0);
        instr(0, 4'hE, 6, 0);
        instr(0, 4'h0, 6, 0);
        instr(0, 4'h2, 6, 0);
        instr(0, 4'hE, 6, 0);
        instr(0, 4'hF, 4, 0);
        cyc(0, 1'b1, 4'h0, 6'b001000, W_HLT);

        // Short-cycle instance: LDA 5, OUT 4, NOP 4, ADD/SUB 6.
        instr(1, 4'h0, 5, 0);
        instr(1, 4'hE, 4, 0);
        instr(1, 4'h7, 4, 0);
        instr(1, 4'h1, 6, 0);
        instr(1, 4'h2, 6, 0);
        instr(1, 4'h0, 1, 0);

        @(posedge CLK);
        #2;
        done = 1'b1;
        repeat (5) @(posedge CLK);
        $display("FAIL timeout: monitor did not finish");
        $fatal(1);
    end

endmodule
